// File: rtl/pipeline_hazard_controller.sv
// Stall/flush controller for a five-stage in-order pipeline. Load-use stalls, redirect flushes
// and memory holds are decided combinationally each cycle; state and perf counters live in flops.
module pipeline_hazard_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  decodeRs1,
    input  logic [4:0]  decodeRs2,
    input  logic        decodeUsesRs1,
    input  logic        decodeUsesRs2,
    input  logic [4:0]  executeRd,
    input  logic        executeMemoryReadEnable,
    input  logic        executePcUpdate,
    input  logic        memoryBusy,
    input  logic        clearCounters,
    output logic        pcWriteEnable,
    output logic        fetchDecodeWriteEnable,
    output logic        decodeExecuteWriteEnable,
    output logic        executeMemoryWriteEnable,
    output logic        fetchDecodeFlush,
    output logic        decodeExecuteFlush,
    output logic [1:0]  controllerState,
    output logic [15:0] stallCycleCount,
    output logic [15:0] redirectCount
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2,
        REDIRECT   = 2'd3
    } state_t;

    state_t state;
    state_t next_state;
    logic   load_use_hazard;
    logic   redirect_event;

    assign load_use_hazard = executeMemoryReadEnable && (executeRd != 5'd0) &&
                             ((decodeUsesRs1 && (decodeRs1 == executeRd)) ||
                              (decodeUsesRs2 && (decodeRs2 == executeRd)));

    assign controllerState = state;

    // NOTE: non-blocking assignments for all flop state so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // NOTE: every output gets a default before the priority chain, so no path infers a latch.
    always_comb begin
        pcWriteEnable            = 1'b0;
        fetchDecodeWriteEnable   = 1'b0;
        decodeExecuteWriteEnable = 1'b0;
        executeMemoryWriteEnable = 1'b0;
        fetchDecodeFlush         = 1'b0;
        decodeExecuteFlush       = 1'b0;
        redirect_event           = 1'b0;
        next_state               = RUN;

        // While reset is asserted the pipeline is frozen with no flushes.
        if (reset) begin
            if (memoryBusy) begin
                next_state = MEM_WAIT;
            end else if (executePcUpdate) begin
                pcWriteEnable            = 1'b1;
                fetchDecodeWriteEnable   = 1'b1;
                decodeExecuteWriteEnable = 1'b1;
                executeMemoryWriteEnable = 1'b1;
                fetchDecodeFlush         = 1'b1;
                decodeExecuteFlush       = 1'b1;
                redirect_event           = 1'b1;
                next_state               = REDIRECT;
            end else if (load_use_hazard && (state != REDIRECT)) begin
                // Hold PC and fetch/decode, inject a bubble behind the load.
                decodeExecuteWriteEnable = 1'b1;
                decodeExecuteFlush       = 1'b1;
                executeMemoryWriteEnable = 1'b1;
                next_state               = LOAD_STALL;
            end else begin
                pcWriteEnable            = 1'b1;
                fetchDecodeWriteEnable   = 1'b1;
                decodeExecuteWriteEnable = 1'b1;
                executeMemoryWriteEnable = 1'b1;
                next_state               = RUN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stallCycleCount <= 16'd0;
            redirectCount   <= 16'd0;
        end else if (clearCounters) begin
            stallCycleCount <= 16'd0;
            redirectCount   <= 16'd0;
        end else begin
            if (!pcWriteEnable && (stallCycleCount != 16'hFFFF)) begin
                stallCycleCount <= stallCycleCount + 16'd1;
            end
            if (redirect_event && (redirectCount != 16'hFFFF)) begin
                redirectCount <= redirectCount + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Scoreboarded bench: stimulus pushes the reference model's expected outputs, and a negedge
// monitor pops and compares them against the controller's outputs.
module tb_pipeline_hazard_controller;

    logic        clock;
    logic        reset;
    logic [4:0]  decodeRs1;
    logic [4:0]  decodeRs2;
    logic        decodeUsesRs1;
    logic        decodeUsesRs2;
    logic [4:0]  executeRd;
    logic        executeMemoryReadEnable;
    logic        executePcUpdate;
    logic        memoryBusy;
    logic        clearCounters;
    logic        pcWriteEnable;
    logic        fetchDecodeWriteEnable;
    logic        decodeExecuteWriteEnable;
    logic        executeMemoryWriteEnable;
    logic        fetchDecodeFlush;
    logic        decodeExecuteFlush;
    logic [1:0]  controllerState;
    logic [15:0] stallCycleCount;
    logic [15:0] redirectCount;

    pipeline_hazard_controller dut (
        .clock                    (clock),
        .reset                    (reset),
        .decodeRs1                (decodeRs1),
        .decodeRs2                (decodeRs2),
        .decodeUsesRs1            (decodeUsesRs1),
        .decodeUsesRs2            (decodeUsesRs2),
        .executeRd                (executeRd),
        .executeMemoryReadEnable  (executeMemoryReadEnable),
        .executePcUpdate          (executePcUpdate),
        .memoryBusy               (memoryBusy),
        .clearCounters            (clearCounters),
        .pcWriteEnable            (pcWriteEnable),
        .fetchDecodeWriteEnable   (fetchDecodeWriteEnable),
        .decodeExecuteWriteEnable (decodeExecuteWriteEnable),
        .executeMemoryWriteEnable (executeMemoryWriteEnable),
        .fetchDecodeFlush         (fetchDecodeFlush),
        .decodeExecuteFlush       (decodeExecuteFlush),
        .controllerState          (controllerState),
        .stallCycleCount          (stallCycleCount),
        .redirectCount            (redirectCount)
    );

    typedef struct {
        string       tag;
        logic [3:0]  we;      // {pc, fd, de, em}
        logic [1:0]  flush;   // {fd, de}
        logic [1:0]  state;
        logic [15:0] stalls;
        logic [15:0] redirects;
    } expect_t;

    expect_t scoreboard[$];
    int      vectors     = 0;
    int      miscompares = 0;

    // Reference model: architectural mode plus the two counters, kept as plain integers.
    int m_mode;       // 0 run, 1 load stall, 2 memory wait, 3 redirect
    int m_stalls;
    int m_redirects;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [15:0] actual, input logic [15:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, actual, required);
        end
    endtask

    always @(negedge clock) begin
        if (scoreboard.size() > 0) begin
            expect_t e;
            e = scoreboard.pop_front();
            check({e.tag, ".writeEnables"},
                  {12'd0, pcWriteEnable, fetchDecodeWriteEnable, decodeExecuteWriteEnable, executeMemoryWriteEnable},
                  {12'd0, e.we});
            check({e.tag, ".flushes"}, {14'd0, fetchDecodeFlush, decodeExecuteFlush}, {14'd0, e.flush});
            check({e.tag, ".state"}, {14'd0, controllerState}, {14'd0, e.state});
            check({e.tag, ".stallCycleCount"}, stallCycleCount, e.stalls);
            check({e.tag, ".redirectCount"}, redirectCount, e.redirects);
        end
    end

    // Drive one cycle of inputs (between edges), queue the expectation, then advance the model.
    task automatic apply(input string tag, input logic rst, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic [4:0] rd, input logic ld,
                         input logic pcu, input logic busy, input logic clr);
        expect_t e;
        bit      hazard;
        int      next_mode;
        bit      redirect;
        reset                   = rst;
        decodeRs1               = rs1;
        decodeRs2               = rs2;
        decodeUsesRs1           = u1;
        decodeUsesRs2           = u2;
        executeRd               = rd;
        executeMemoryReadEnable = ld;
        executePcUpdate         = pcu;
        memoryBusy              = busy;
        clearCounters           = clr;

        if (!rst) begin
            m_mode      = 0;
            m_stalls    = 0;
            m_redirects = 0;
        end
        hazard    = ld && rd != 0 && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
        redirect  = 1'b0;
        next_mode = 0;
        e.tag     = tag;
        if (!rst) begin
            e.we = 4'b0000; e.flush = 2'b00;
        end else if (busy) begin
            e.we = 4'b0000; e.flush = 2'b00; next_mode = 2;
        end else if (pcu) begin
            e.we = 4'b1111; e.flush = 2'b11; next_mode = 3; redirect = 1'b1;
        end else if (hazard && m_mode != 3) begin
            e.we = 4'b0011; e.flush = 2'b01; next_mode = 1;
        end else begin
            e.we = 4'b1111; e.flush = 2'b00;
        end
        e.state     = 2'(m_mode);
        e.stalls    = 16'(m_stalls);
        e.redirects = 16'(m_redirects);
        scoreboard.push_back(e);

        @(posedge clock);
        if (rst) begin
            m_mode = next_mode;
            if (clr) begin
                m_stalls    = 0;
                m_redirects = 0;
            end else begin
                if (!e.we[3] && m_stalls < 65535) m_stalls++;
                if (redirect && m_redirects < 65535) m_redirects++;
            end
        end
        #1;
    endtask

    task automatic idle(input string tag);
        apply(tag, 1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; decodeRs1 = '0; decodeRs2 = '0; decodeUsesRs1 = 1'b0; decodeUsesRs2 = 1'b0;
        executeRd = '0; executeMemoryReadEnable = 1'b0; executePcUpdate = 1'b0;
        memoryBusy = 1'b0; clearCounters = 1'b0;
        m_mode = 0; m_stalls = 0; m_redirects = 0;
        @(posedge clock);
        #1;

        // Reset state, with inputs that would otherwise stall.
        apply("reset", 1'b0, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
        apply("reset", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        idle("first_run");

        // Load-use on rs2 only, then back to RUN.
        apply("load_use_rs2", 1'b1, 5'd9, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("after_stall");
        // Matching register but not a load, or rs not actually read: no stall.
        apply("not_load", 1'b1, 5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        apply("unused_rs", 1'b1, 5'd5, 5'd5, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        // Load to x0 never stalls.
        apply("load_x0", 1'b1, 5'd0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);

        // Redirect wins over load-use; the hazard is masked the next cycle.
        apply("redirect_hazard", 1'b1, 5'd4, 5'd1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0, 1'b0);
        apply("masked_hazard", 1'b1, 5'd4, 5'd1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        apply("hazard_after", 1'b1, 5'd4, 5'd1, 1'b1, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        idle("run");

        // Memory hold for 3 cycles over a pending redirect, then the redirect goes through.
        for (int i = 0; i < 3; i++)
            apply("busy_redirect", 1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0);
        apply("redirect_release", 1'b1, 5'd2, 5'd2, 1'b1, 1'b1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
        idle("run");

        // Reset asserted between edges while in MEM_WAIT.
        apply("busy", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply("busy", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply("reset_mid_wait", 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        idle("post_reset");

        // Randomised traffic over a small register space so hazards are frequent.
        for (int i = 0; i < 3000; i++) begin
            apply("random",
                  ($urandom_range(63) != 0),
                  5'($urandom_range(3)), 5'($urandom_range(3)),
                  1'($urandom_range(1)), 1'($urandom_range(1)),
                  5'($urandom_range(3)), ($urandom_range(2) != 0),
                  ($urandom_range(5) == 0), ($urandom_range(7) == 0),
                  ($urandom_range(31) == 0));
        end

        // Counter saturation: long memory hold passes 0xFFFE and pins at 0xFFFF, then clear.
        apply("clear", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 65537; i++)
            apply("saturate", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        apply("clear_sat", 1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1);
        idle("cleared");
        idle("cleared");

        #10;
        vectors++;
        if (scoreboard.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, expected 0", scoreboard.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 SHALL have: clock  in  1  rising-edge clock for all state.
REQ-002 SHALL have: reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have: decodeRs1, decodeRs2  in  5 each  source registers of the instruction in decode.
REQ-004 SHALL have: decodeUsesRs1, decodeUsesRs2  in  1 each  decode instruction actually reads rs1/rs2.
REQ-005 SHALL have: executeRd  in  5  destination of the instruction held in the decode-to-execute register.
REQ-006 SHALL have: executeMemoryReadEnable  in  1  execute-stage instruction is a load.
REQ-007 SHALL have: executePcUpdate  in  1  execute stage resolved a taken branch/jump.
REQ-008 SHALL have: memoryBusy  in  1  data memory not ready; whole pipeline must hold.
REQ-009 SHALL have: clearCounters  in  1  synchronous clear of the performance counters.
REQ-010 SHALL have: pcWriteEnable, fetchDecodeWriteEnable, decodeExecuteWriteEnable, executeMemoryWriteEnable  out  1 each  stage-register load enables.
REQ-011 SHALL have: fetchDecodeFlush, decodeExecuteFlush  out  1 each  load a bubble (all control fields 0) into that register.
REQ-012 SHALL have: controllerState  out  2  current state (RUN=0, LOAD_STALL=1, MEM_WAIT=2, REDIRECT=3).
REQ-013 SHALL have: stallCycleCount, redirectCount  out  16 each  saturating performance counters.

Function
REQ-014 SHALL hold state and counters in flops; control outputs SHALL be combinational from current state and present inputs (zero-cycle decision latency).
REQ-015 SHALL define loadUseHazard = executeMemoryReadEnable & executeRd!=0 & ((decodeUsesRs1 & decodeRs1==executeRd) | (decodeUsesRs2 & decodeRs2==executeRd)).
REQ-016 SHALL evaluate per cycle with fixed priority: memoryBusy > executePcUpdate > loadUseHazard > normal.
REQ-017 memoryBusy=1 (any state): all four write enables 0, both flushes 0, next state MEM_WAIT; executePcUpdate and loadUseHazard ignored that cycle.
REQ-018 executePcUpdate=1, memoryBusy=0: all write enables 1, fetchDecodeFlush=1, decodeExecuteFlush=1, next state REDIRECT.
REQ-019 loadUseHazard=1, higher priorities 0, state!=REDIRECT: pcWriteEnable=0, fetchDecodeWriteEnable=0, decodeExecuteWriteEnable=1, decodeExecuteFlush=1, executeMemoryWriteEnable=1, next state LOAD_STALL.
REQ-020 In REDIRECT, loadUseHazard SHALL be masked (decode holds a flushed bubble).
REQ-021 Normal: all write enables 1, flushes 0, next state RUN.
REQ-022 LOAD_STALL and REDIRECT SHALL last exactly one cycle unless a higher-priority event occurs; MEM_WAIT SHALL persist while memoryBusy=1 and leave in the first cycle memoryBusy=0, that cycle evaluated by REQ-016.
REQ-023 A flush and a write enable to the same register SHALL never both be 0 while flush is 1 (flush implies load).
REQ-024 stallCycleCount SHALL increment by 1 on each clock edge where pcWriteEnable=0; redirectCount SHALL increment on each edge where REQ-018 applies; both saturate at 0xFFFF.
REQ-025 clearCounters=1 SHALL zero both counters on the next edge, overriding any increment that cycle.

Reset
REQ-026 reset=0 SHALL immediately force controllerState=RUN, both counters 0, all write enables 0, both flushes 0, independent of clock.
REQ-027 After reset deasserts, the first rising edge SHALL see normal REQ-016 evaluation; a reset mid-stall SHALL discard the stall with no residual state.

Verification
REQ-028 Load x5 in execute, decode uses rs2=5 -> one cycle pcWriteEnable=0, decodeExecuteFlush=1, state LOAD_STALL, stallCycleCount 0->1; next cycle RUN.
REQ-029 Load with executeRd=0, decode rs1=0 -> no stall, all enables 1.
REQ-030 executePcUpdate=1 together with loadUseHazard=1 -> both flushes 1, pcWriteEnable=1, state REDIRECT, redirectCount +1; following cycle hazard masked.
REQ-031 memoryBusy=1 for 3 cycles with executePcUpdate=1 -> enables 0 for 3 cycles, stallCycleCount +3, then redirect applied on first non-busy cycle.
REQ-032 Counter at 0xFFFE, two stall cycles -> 0xFFFF held; clearCounters=1 -> 0.
REQ-033 reset=0 asserted during MEM_WAIT between edges -> outputs zero immediately, state RUN, counters 0.
